// File: rtl/ascon_decrypt_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ascon_pack : shared types, IV, round-constant helper and FSM encoding for   |
// |              the ASCON-128 decryption engine                                |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package ascon_pack;

  // Word 0 is the rate word x0.
  typedef logic [4:0][63:0] state_t;

  localparam logic [63:0] c_IV = 64'h80400c0600000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_AD    = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DATA  = 3'd4,
    ST_FINAL = 3'd5,
    ST_DONE  = 3'd6
  } dec_state_e;

  // 0xf0 - r*0x0f equals {~r, r} in nibbles for r = 0..11.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hf - r, r};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_decrypt_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ascon_decrypt_if : message/handshake bundle of the ASCON-128 decryptor      |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
interface ascon_decrypt_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [63:0]  ad_i;
  logic [127:0] tag_i;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic         ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_o;
  logic         busy_o;

  modport master (
    output start_i, key_i, nonce_i, ad_i, tag_i, data_i, data_valid_i,
    input  ready_o, plain_o, plain_valid_o, tag_o, auth_ok_o, end_o, busy_o
  );

  modport slave (
    input  start_i, key_i, nonce_i, ad_i, tag_i, data_i, data_valid_i,
    output ready_o, plain_o, plain_valid_o, tag_o, auth_ok_o, end_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ascon_round : one combinational ASCON round (constant, S-box, diffusion)    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ascon_round
  import ascon_pack::*;
(
  input  state_t     i_x,
  input  logic [3:0] i_rnd,
  output state_t     o_x
);

  logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

  // Constant addition folded into the S-box input mixing.
  assign w_a0 = i_x[0] ^ i_x[4];
  assign w_a1 = i_x[1];
  assign w_a2 = i_x[2] ^ {56'h0, round_const(i_rnd)} ^ i_x[1];
  assign w_a3 = i_x[3];
  assign w_a4 = i_x[4] ^ i_x[3];

  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

  assign w_s0 = w_b0 ^ w_b4;
  assign w_s1 = w_b1 ^ w_b0;
  assign w_s2 = ~w_b2;
  assign w_s3 = w_b3 ^ w_b2;
  assign w_s4 = w_b4;

  assign o_x[0] = w_s0 ^ rotr(w_s0, 19) ^ rotr(w_s0, 28);
  assign o_x[1] = w_s1 ^ rotr(w_s1, 61) ^ rotr(w_s1, 39);
  assign o_x[2] = w_s2 ^ rotr(w_s2, 1)  ^ rotr(w_s2, 6);
  assign o_x[3] = w_s3 ^ rotr(w_s3, 10) ^ rotr(w_s3, 17);
  assign o_x[4] = w_s4 ^ rotr(w_s4, 7)  ^ rotr(w_s4, 41);

endmodule
`default_nettype wire

// File: rtl/ascon_decrypt.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ascon_decrypt : iterative ASCON-128 authenticated decryption engine         |
// |                 ASCON_DEC_ROUND2_EN cascades two rounds per clock           |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module ascon_decrypt
  import ascon_pack::*;
#(
  parameter int N_BLOCKS = 4
)
(
  input  logic           clock_i,
  input  logic           resetb_i,
  ascon_decrypt_if.slave bus
);

  localparam int                 c_BLK_W    = $clog2(N_BLOCKS + 1);
  localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(N_BLOCKS);
`ifdef ASCON_DEC_ROUND2_EN
  localparam logic [3:0]         c_STEP     = 4'd2;
`else
  localparam logic [3:0]         c_STEP     = 4'd1;
`endif

  dec_state_e         r_state;
  dec_state_e         w_state_nxt;
  state_t             r_x;
  state_t             w_perm;
  logic [127:0]       r_key;
  logic [127:0]       r_tag_exp;
  logic [63:0]        r_ad;
  logic [3:0]         r_rnd;
  logic [c_BLK_W-1:0] r_blk;
  logic [63:0]        r_plain;
  logic               r_plain_valid;
  logic [127:0]       r_tag;
  logic               r_auth_ok;

  logic               w_in_rounds;
  logic               w_long_phase;
  logic [3:0]         w_rnd_last;
  logic               w_last;
  logic [3:0]         w_ridx;
  logic               w_accept;
  logic               w_msg_done;
  logic [127:0]       w_tag;

  assign w_in_rounds  = (r_state == ST_INIT) || (r_state == ST_AD) ||
                        (r_state == ST_DATA) || (r_state == ST_FINAL);
  assign w_long_phase = (r_state == ST_INIT) || (r_state == ST_FINAL);
  assign w_rnd_last   = w_long_phase ? (4'd12 - c_STEP) : (4'd6 - c_STEP);
  assign w_last       = (r_rnd == w_rnd_last);
  // Six-round phases run the tail of the schedule, rounds 6..11.
  assign w_ridx       = w_long_phase ? r_rnd : (r_rnd + 4'd6);
  assign w_accept     = (r_state == ST_WAIT) && bus.data_valid_i;
  assign w_msg_done   = (r_blk == c_BLK_LAST);
  assign w_tag        = {w_perm[3], w_perm[4]} ^ r_key;

`ifdef ASCON_DEC_ROUND2_EN
  state_t w_mid;
  ascon_round u_round0 (.i_x(r_x),   .i_rnd(w_ridx),         .o_x(w_mid));
  ascon_round u_round1 (.i_x(w_mid), .i_rnd(w_ridx + 4'd1), .o_x(w_perm));
`else
  ascon_round u_round0 (.i_x(r_x),   .i_rnd(w_ridx),         .o_x(w_perm));
`endif

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start_i) w_state_nxt = ST_INIT;
      ST_INIT:  if (w_last)      w_state_nxt = ST_AD;
      ST_AD:    if (w_last)      w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_accept)    w_state_nxt = ST_DATA;
      ST_DATA:  if (w_last)      w_state_nxt = w_msg_done ? ST_FINAL : ST_WAIT;
      ST_FINAL: if (w_last)      w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_x           <= '0;
      r_key         <= '0;
      r_tag_exp     <= '0;
      r_ad          <= '0;
      r_rnd         <= '0;
      r_blk         <= '0;
      r_plain       <= '0;
      r_plain_valid <= 1'b0;
      r_tag         <= '0;
      r_auth_ok     <= 1'b0;
    end else begin
      r_plain_valid <= 1'b0;
      if (w_in_rounds) r_rnd <= w_last ? 4'd0 : (r_rnd + c_STEP);
      else             r_rnd <= 4'd0;

      case (r_state)
        ST_IDLE: if (bus.start_i) begin
          r_x[0]    <= c_IV;
          r_x[1]    <= bus.key_i[127:64];
          r_x[2]    <= bus.key_i[63:0];
          r_x[3]    <= bus.nonce_i[127:64];
          r_x[4]    <= bus.nonce_i[63:0];
          r_key     <= bus.key_i;
          r_tag_exp <= bus.tag_i;
          r_ad      <= bus.ad_i;
          r_auth_ok <= 1'b0;
          r_blk     <= '0;
        end
        ST_INIT: begin
          r_x <= w_perm;
          if (w_last) begin
            r_x[0] <= w_perm[0] ^ r_ad;
            r_x[3] <= w_perm[3] ^ r_key[127:64];
            r_x[4] <= w_perm[4] ^ r_key[63:0];
          end
        end
        ST_AD: begin
          r_x <= w_perm;
          if (w_last) r_x[4] <= w_perm[4] ^ 64'd1;
        end
        ST_WAIT: if (w_accept) begin
          r_plain       <= r_x[0] ^ bus.data_i;
          r_x[0]        <= bus.data_i;
          r_blk         <= r_blk + c_BLK_W'(1);
          r_plain_valid <= 1'b1;
        end
        ST_DATA: begin
          r_x <= w_perm;
          // Whole-block messages end with an empty padded block, merged with key injection.
          if (w_last && w_msg_done) begin
            r_x[0] <= w_perm[0] ^ 64'h8000000000000000;
            r_x[1] <= w_perm[1] ^ r_key[127:64];
            r_x[2] <= w_perm[2] ^ r_key[63:0];
          end
        end
        ST_FINAL: begin
          r_x <= w_perm;
          if (w_last) begin
            r_tag     <= w_tag;
            r_auth_ok <= (w_tag == r_tag_exp);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o       = (r_state == ST_WAIT);
  assign bus.busy_o        = (r_state != ST_IDLE);
  assign bus.end_o         = (r_state == ST_DONE);
  assign bus.plain_o       = r_plain;
  assign bus.plain_valid_o = r_plain_valid;
  assign bus.tag_o         = r_tag;
  assign bus.auth_ok_o     = r_auth_ok;

endmodule
`default_nettype wire

// File: doc/ascon_decrypt.md
# ascon_decrypt

Iterative ASCON-128 authenticated-decryption engine, the receive-side counterpart of the encryption top level. It takes key, nonce, one pre-padded associated-data block, an expected tag and a fixed number of 64-bit ciphertext blocks. It returns the plaintext blocks and a tag-match verdict. The 320-bit permutation state is held in a register and advanced by a combinational round function, one round per clock by default.

## Interface
Parameters:
- N_BLOCKS, default 4: full 64-bit ciphertext blocks per message; minimum 1.

Ports:
- clock_i  in  1  system clock; the only clock.
- resetb_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a message. Sampled in IDLE only; key_i, nonce_i, ad_i and tag_i are sampled in the same cycle.
- key_i  in  128  key K (K[127:64] is the high word).
- nonce_i  in  128  nonce N.
- ad_i  in  64  single associated-data block, already padded by the caller.
- tag_i  in  128  expected tag.
- data_i  in  64  ciphertext block.
- data_valid_i  in  1  ciphertext block present on data_i.
- ready_o  out  1  block accepted on an edge where data_valid_i & ready_o.
- plain_o  out  64  recovered plaintext block; held until the next accept.
- plain_valid_o  out  1  one-cycle pulse after each accept.
- tag_o  out  128  computed tag.
- auth_ok_o  out  1  tag_o == sampled tag_i; valid once end_o has pulsed.
- end_o  out  1  one-cycle pulse when the message completes.
- busy_o  out  1  high in every state except IDLE.

## Operation
- The state is x0..x4, with x0 as the rate word.
- ASCON-128 uses a=12 and b=6. IV = 0x80400c0600000000. The round constant for global round r (0..11) is 0xf0 − r·0x0f. The 6-round permutation uses r=6..11.
- FSM states: IDLE → INIT → AD → WAIT → DATA → (WAIT or FINAL) → DONE → IDLE.
- IDLE, on start_i:
  - load x = {IV, K_hi, K_lo, N_hi, N_lo};
  - latch K and tag_i;
  - clear auth_ok_o and the block counter.
- INIT: 12 rounds. The edge that applies the last round also applies x3 ^= K_hi, x4 ^= K_lo, then x0 ^= ad_i.
- AD: 6 rounds. The last round edge also applies x4 ^= 1.
- WAIT: ready_o = 1. On accept:
  - plain_o <= x0 ^ data_i;
  - x0 <= data_i;
  - counter increments;
  - go to DATA.
- DATA: 6 rounds. The last round edge then depends on the counter:
  - counter < N_BLOCKS: return to WAIT.
  - counter == N_BLOCKS: apply the empty final padded block and pre-finalization in one step (x0 ^= 0x8000000000000000, x1 ^= K_hi, x2 ^= K_lo), then go to FINAL.
- FINAL: 12 rounds. The last round edge registers:
  - tag_o = {x3, x4} ^ K;
  - auth_ok_o = (that value == latched tag).
- DONE: end_o = 1 for exactly one cycle, then IDLE.
- A round counter sequences INIT/AD/DATA/FINAL. The block counter is $clog2(N_BLOCKS+1) bits wide and never wraps; it is cleared only at start.
- Boundary rules:
  - start_i while busy_o is ignored.
  - data_valid_i while ready_o=0 is not accepted; the caller must hold the block.
  - Plaintext is released before authentication completes. Consumers gate on auth_ok_o.
  - Reset at any time returns to IDLE with all outputs at reset values, discarding the message.

## Timing
- Reset values: ready_o, plain_valid_o, end_o, busy_o, auth_ok_o = 0; plain_o, tag_o = 0; FSM in IDLE.
- Let R be rounds per clock (1 by default).
- start_i sampled at edge k. Init completes at edge k+12/R, AD at k+18/R, so ready_o is high from the cycle after edge k+18/R.
- Accept at edge m:
  - plain_valid_o is high for the cycle after m;
  - ready_o drops at m and returns after edge m+6/R (non-last block).
- Last accept at edge m: tag_o and auth_ok_o update at edge m+18/R; end_o is high for the following cycle.
- Back-to-back start is possible the cycle after end_o.

## Configuration
- ASCON_DEC_ROUND2_EN:
  - Defined: two ascon_round instances are cascaded and R=2, so every round count above is halved (init 6 cycles, AD/DATA 3, FINAL 6).
  - Undefined: one instance, R=1.
- Ports and results are identical in both builds.

## Structure
- Shared in ascon_pack:
  - state_t (array of five 64-bit words);
  - IV constant;
  - round-constant function of r;
  - FSM state enum.
- Sub-module ascon_round: purely combinational single round (constant addition, 5-bit S-box layer, linear diffusion layer). Inputs are state_t and the 4-bit round index; output is state_t.

## Test plan
- Round trip, N_BLOCKS=4:
  - Stimulus: encrypt with the team's encryption top level using key=nonce=000102…0F, ad=0x4153434F4E800000, plaintext blocks 0x1111…11, 0x2222…22, 0x3333…33, 0x4444…44. Decrypt ciphertext and tag.
  - Response: plain_o sequence matches, tag_o equals the encryptor's tag, auth_ok_o=1, end_o one pulse.
- Corrupted tag: same message with tag_i bit 0 flipped → identical plaintexts, auth_ok_o=0.
- Latency with R=1: start at edge k → ready_o first high after edge k+18; last accept at edge m → end_o high in the cycle after edge m+18. With ASCON_DEC_ROUND2_EN: k+9 and m+9.
- Handshake stall: hold data_valid_i low 10 cycles in WAIT, and pulse start_i mid-message → no accept, no restart, results unchanged versus the unstalled run.
- Reset mid-DATA (after block 2): assert resetb_i=0 → all outputs 0 and IDLE. A fresh full message afterwards decrypts correctly with auth_ok_o=1.
